// File: rtl/sequence_checker_if.sv
// Receive byte stream carrying the fixed test sequence.
//
// Handshake: valid-only, no backpressure. A byte on data is consumed on
// every rising clk edge where valid is 1. When valid is 0, data is ignored
// and the receiver holds all of its state. There is no ready signal; the
// receiver always accepts.
//
// Signals:
//   valid : byte qualifier
//   data  : received byte
// Modports:
//   master : drives valid/data (generator or path under test)
//   slave  : samples valid/data (sequence_checker)
interface sequence_checker_if;
  logic       valid;
  logic [7:0] data;

  modport master (output valid, output data);
  modport slave  (input  valid, input  data);
endinterface

// File: rtl/sequence_checker.sv
// Receive-side checker for the 8-byte test sequence
// AF, BC, E2, 78, FF, E2, 0B, 8D.
//
// The checker hunts for AF, then tracks the sequence byte by byte. It
// declares lock after LOCK_PERIODS consecutive clean sequences, and reports
// each mismatch as a one-cycle pulse and in a saturating counter.
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   rx        : sequence_checker_if.slave (valid, data)
//   locked    : level, checker is in LOCKED
//   seq_done  : 1-cycle pulse, final byte (8D) of a sequence matched
//   error     : 1-cycle pulse, mismatch while in SYNC or LOCKED
//   err_count : saturating mismatch count (ERR_CNT_W bits)
//   exp_data  : byte expected on the next valid cycle (AF while hunting)
//   dbg_state : current FSM state (0 HUNT, 1 SYNC, 2 LOCKED)
module sequence_checker #(
  parameter int LOCK_PERIODS = 2,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_checker_if.slave    rx,
  output logic                 locked,
  output logic                 seq_done,
  output logic                 error,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [7:0]           exp_data,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]           LOCK_TARGET = 4'(LOCK_PERIODS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = {ERR_CNT_W{1'b1}};

  function automatic logic [7:0] seq_byte(input logic [2:0] i);
    case (i)
      3'd0:    seq_byte = 8'hAF;
      3'd1:    seq_byte = 8'hBC;
      3'd2:    seq_byte = 8'hE2;
      3'd3:    seq_byte = 8'h78;
      3'd4:    seq_byte = 8'hFF;
      3'd5:    seq_byte = 8'hE2;
      3'd6:    seq_byte = 8'h0B;
      default: seq_byte = 8'h8D;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic       done_d, err_d;
  logic [7:0] exp_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (rx.valid) begin
      case (state_q)
        HUNT: begin
          // Only AF starts a sequence; anything else is silently skipped.
          if (rx.data == 8'hAF) begin
            state_d = SYNC;
            idx_d   = 3'd1;
            gcnt_d  = 4'd0;
          end
        end
        SYNC, LOCKED: begin
          if (rx.data == seq_byte(idx_q)) begin
            idx_d = idx_q + 3'd1;  // wraps 7 -> 0
            if (idx_q == 3'd7) begin
              done_d = 1'b1;
              // Good-sequence counting only matters on the way to lock.
              if (state_q == SYNC) begin
                gcnt_d = gcnt_q + 4'd1;
                if (gcnt_q + 4'd1 == LOCK_TARGET) state_d = LOCKED;
              end
            end
          end else begin
            err_d  = 1'b1;
            gcnt_d = 4'd0;
            // A mismatching AF is treated as the start of a new sequence.
            if (rx.data == 8'hAF) begin
              state_d = SYNC;
              idx_d   = 3'd1;
            end else begin
              state_d = HUNT;
              idx_d   = 3'd0;
            end
          end
        end
        default: begin
          state_d = HUNT;
          idx_d   = 3'd0;
          gcnt_d  = 4'd0;
        end
      endcase
    end

    exp_d = (state_d == HUNT) ? 8'hAF : seq_byte(idx_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HUNT;
      idx_q     <= 3'd0;
      gcnt_q    <= 4'd0;
      locked    <= 1'b0;
      seq_done  <= 1'b0;
      error     <= 1'b0;
      err_count <= '0;
      exp_data  <= 8'hAF;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gcnt_q   <= gcnt_d;
      locked   <= (state_d == LOCKED);
      seq_done <= done_d;
      error    <= err_d;
      exp_data <= exp_d;
      if (err_d && (err_count != ERR_MAX)) err_count <= err_count + ERR_CNT_W'(1);
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
module tb_sequence_checker;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sequence_checker_if bus ();

  logic       a_locked, a_done, a_err;
  logic [7:0] a_cnt, a_exp;
  logic [1:0] a_state;
  logic       b_locked, b_done, b_err;
  logic [1:0] b_cnt;
  logic [7:0] b_exp;
  logic [1:0] b_state;

  sequence_checker #(.LOCK_PERIODS(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(rst), .rx(bus),
    .locked(a_locked), .seq_done(a_done), .error(a_err),
    .err_count(a_cnt), .exp_data(a_exp), .dbg_state(a_state)
  );

  // Narrow-counter instance sharing the same stream, for saturation.
  sequence_checker #(.LOCK_PERIODS(2), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset(rst), .rx(bus),
    .locked(b_locked), .seq_done(b_done), .error(b_err),
    .err_count(b_cnt), .exp_data(b_exp), .dbg_state(b_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] seq_tbl [8];
  int         m_state;  // 0 HUNT, 1 SYNC, 2 LOCKED
  int         m_idx, m_gcnt, m_err8, m_err2;
  logic       m_done, m_err;

  // {locked, seq_done, error, err_count8, err_count2, exp_data}
  logic [20:0] exp_q[$];

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_gcnt = 0; m_err8 = 0; m_err2 = 0;
    m_done = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d);
    logic [7:0] e;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d == 8'hAF) begin m_state = 1; m_idx = 1; m_gcnt = 0; end
      end else if (d == seq_tbl[m_idx]) begin
        if (m_idx == 7) begin
          m_done = 1'b1;
          if (m_state == 1) begin
            m_gcnt++;
            if (m_gcnt == 2) m_state = 2;
          end
        end
        m_idx = (m_idx + 1) % 8;
      end else begin
        m_err = 1'b1;
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3) m_err2++;
        m_gcnt = 0;
        if (d == 8'hAF) begin m_state = 1; m_idx = 1; end
        else begin m_state = 0; m_idx = 0; end
      end
    end
    e = (m_state == 0) ? 8'hAF : seq_tbl[m_idx];
    exp_q.push_back({(m_state == 2), m_done, m_err, 8'(m_err8), 2'(m_err2), e});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) begin
    logic [20:0] want, got;
    #1;
    if (!rst && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {a_locked, a_done, a_err, a_cnt, b_cnt, a_exp};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL scoreboard t=%0t actual=%h required=%h", $time, got, want);
      end
      checks++;
      if (a_done && a_err) begin
        failures++;
        $display("FAIL pulse_exclusive actual=11 required=not both");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    exp_q.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns 2 time units after the sampling edge, outputs settled.
  task automatic drive_byte(input logic v, input logic [7:0] d);
    @(negedge clk);
    bus.valid = v;
    bus.data  = d;
    model_step(v, d);
    @(posedge clk);
    #2;
  endtask

  task automatic send_seq();
    for (int i = 0; i < 8; i++) drive_byte(1'b1, seq_tbl[i]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_locked, a_done, a_err, a_cnt, a_exp, a_state} !== {3'b000, 8'h00, 8'hAF, 2'd0}) begin
      failures++;
      $display("FAIL reset_state actual=%b%b%b cnt=%h exp=%h st=%0d required=000 cnt=00 exp=af st=0",
               a_locked, a_done, a_err, a_cnt, a_exp, a_state);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean();
    int dones;
    dones = 0;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 8; i++) begin
        drive_byte(1'b1, seq_tbl[i]);
        if (a_done) dones++;
        checks++;
        if (a_done !== (i == 7)) begin
          failures++;
          $display("FAIL clean_seq_done byte=%0d actual=%b required=%b", s*8+i+1, a_done, (i == 7));
        end
      end
      checks++;
      if (a_locked !== (s >= 1)) begin
        failures++;
        $display("FAIL clean_locked seq=%0d actual=%b required=%b", s, a_locked, (s >= 1));
      end
    end
    checks++;
    if (dones != 3 || a_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clean_totals actual dones=%0d cnt=%0d required dones=3 cnt=0", dones, a_cnt);
    end
  endtask

  task automatic test_lock_error();
    // Checker is locked here; corrupt byte index 4.
    for (int i = 0; i < 4; i++) drive_byte(1'b1, seq_tbl[i]);
    drive_byte(1'b1, 8'hFE);
    checks++;
    if ({a_err, a_locked, a_state} !== {1'b1, 1'b0, 2'd0} || a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL lock_error actual err=%b locked=%b st=%0d cnt=%0d required err=1 locked=0 st=0 cnt=1",
               a_err, a_locked, a_state, a_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      drive_byte(1'b1, seq_tbl[i % 8]);
      if (i == 14 || i == 15) begin
        checks++;
        if (a_locked !== (i == 15)) begin
          failures++;
          $display("FAIL relock byte=%0d actual=%b required=%b", i+1, a_locked, (i == 15));
        end
      end
    end
  endtask

  task automatic test_junk();
    logic [7:0] junk [3];
    junk[0] = 8'h00; junk[1] = 8'h12; junk[2] = 8'hE2;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_byte(1'b1, junk[i]);
      checks++;
      if (a_err !== 1'b0 || a_state !== 2'd0) begin
        failures++;
        $display("FAIL junk_ignored byte=%h actual err=%b st=%0d required err=0 st=0", junk[i], a_err, a_state);
      end
    end
    drive_byte(1'b1, 8'hAF);
    checks++;
    if (a_state !== 2'd1 || a_exp !== 8'hBC) begin
      failures++;
      $display("FAIL junk_hunt_exit actual st=%0d exp=%h required st=1 exp=bc", a_state, a_exp);
    end
    for (int i = 1; i < 8; i++) drive_byte(1'b1, seq_tbl[i]);
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL junk_seq_done actual=%b required=1", a_done);
    end
  endtask

  task automatic test_af_restart();
    apply_reset();
    drive_byte(1'b1, 8'hAF);
    drive_byte(1'b1, 8'hBC);
    drive_byte(1'b1, 8'hAF);
    checks++;
    if (a_err !== 1'b1 || a_cnt !== 8'd1 || a_exp !== 8'hBC || a_state !== 2'd1) begin
      failures++;
      $display("FAIL af_restart actual err=%b cnt=%0d exp=%h st=%0d required err=1 cnt=1 exp=bc st=1",
               a_err, a_cnt, a_exp, a_state);
    end
    for (int i = 1; i < 8; i++) drive_byte(1'b1, seq_tbl[i]);
    checks++;
    if (a_done !== 1'b1 || a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL af_restart_done actual done=%b cnt=%0d required done=1 cnt=1", a_done, a_cnt);
    end
  endtask

  task automatic test_gaps();
    int dones;
    dones = 0;
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          int g;
          g = $urandom_range(1, 5);
          for (int k = 0; k < g; k++) begin
            drive_byte(1'b0, 8'($urandom_range(0, 255)));
            if (a_done || a_err) dones += 100;
          end
        end
        drive_byte(1'b1, seq_tbl[i]);
        if (a_done) dones++;
      end
    end
    checks++;
    if (dones != 2 || a_locked !== 1'b1 || a_cnt !== 8'd0) begin
      failures++;
      $display("FAIL gaps actual dones=%0d locked=%b cnt=%0d required dones=2 locked=1 cnt=0",
               dones, a_locked, a_cnt);
    end
  endtask

  task automatic test_err_sat();
    logic [1:0] want2 [5];
    want2[0] = 2'd1; want2[1] = 2'd2; want2[2] = 2'd3; want2[3] = 2'd3; want2[4] = 2'd3;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive_byte(1'b1, 8'hAF);
      drive_byte(1'b1, 8'h00);
      checks++;
      if (b_cnt !== want2[k] || a_cnt !== 8'(k + 1)) begin
        failures++;
        $display("FAIL err_sat n=%0d actual w2=%0d w8=%0d required w2=%0d w8=%0d",
                 k+1, b_cnt, a_cnt, want2[k], k+1);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    send_seq();
    send_seq();
    drive_byte(1'b1, 8'hAF);
    drive_byte(1'b1, 8'hBC);
    drive_byte(1'b1, 8'h00);  // error pulse is high right now
    checks++;
    if (a_err !== 1'b1 || a_cnt !== 8'd1) begin
      failures++;
      $display("FAIL pre_reset actual err=%b cnt=%0d required err=1 cnt=1", a_err, a_cnt);
    end
    send_seq();
    send_seq();
    drive_byte(1'b1, 8'hAF);
    drive_byte(1'b1, 8'hBC);
    drive_byte(1'b1, 8'hE2);
    // Mid-cycle, well away from any clock edge.
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({a_locked, a_done, a_err, a_cnt, a_exp, a_state, b_cnt} !==
        {3'b000, 8'h00, 8'hAF, 2'd0, 2'd0}) begin
      failures++;
      $display("FAIL async_reset actual locked=%b cnt=%0d exp=%h st=%0d required locked=0 cnt=0 exp=af st=0",
               a_locked, a_cnt, a_exp, a_state);
    end
    exp_q.delete();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_byte(1'b1, 8'hAF);
    checks++;
    if (a_state !== 2'd1 || a_exp !== 8'hBC) begin
      failures++;
      $display("FAIL post_reset_hunt actual st=%0d exp=%h required st=1 exp=bc", a_state, a_exp);
    end
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    checks = 0;
    failures = 0;
    seq_tbl[0] = 8'hAF; seq_tbl[1] = 8'hBC; seq_tbl[2] = 8'hE2; seq_tbl[3] = 8'h78;
    seq_tbl[4] = 8'hFF; seq_tbl[5] = 8'hE2; seq_tbl[6] = 8'h0B; seq_tbl[7] = 8'h8D;
    test_reset();
    test_clean();
    test_lock_error();
    test_junk();
    test_af_restart();
    test_gaps();
    test_err_sat();
    test_async_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
# sequence_checker

Receive-side checker for the fixed 8-byte test sequence AF, BC, E2, 78, FF, E2, 0B, 8D driven by the sequence generator. It samples one byte per qualified clock and hunts for the sequence start (8'hAF). It locks after a programmable number of consecutive error-free sequences and reports mismatches as pulses and as a saturating error count. It sits at the far end of the test data path, downstream of the generator and any logic under test.

## Interface
- LOCK_PERIODS, 2, complete consecutive good sequences needed to assert locked; legal 1..15
- ERR_CNT_W, 8, width of err_count
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- valid  input  1  data qualifier; byte on data is consumed only when 1
- data  input  8  received byte
- locked  output  1  level; checker is in LOCKED state
- seq_done  output  1  1-cycle pulse; byte index 7 (8'h8D) matched
- error  output  1  1-cycle pulse; mismatch detected in SYNC or LOCKED
- err_count  output  ERR_CNT_W  saturating mismatch count
- exp_data  output  8  byte expected on the next valid cycle; 8'hAF while hunting

## Operation
- Expected table, fixed: idx0 AF, 1 BC, 2 E2, 3 78, 4 FF, 5 E2, 6 0B, 7 8D. Internal 3-bit idx wraps 7 -> 0.
- Internal good-sequence counter gcnt, 4 bits.
- States are HUNT, SYNC and LOCKED. Transitions are evaluated only when valid=1; with valid=0 all state is held and no pulses are generated.
- HUNT:
  - data==AF: go to SYNC, idx=1, gcnt=0.
  - Any other byte is ignored. No error, no count.
- SYNC, match (data==table[idx]):
  - idx increments.
  - If idx was 7: seq_done pulses and gcnt increments.
  - If gcnt+1==LOCK_PERIODS: go to LOCKED.
- SYNC, mismatch:
  - error pulses and err_count increments (saturating).
  - gcnt is cleared.
  - If data==AF: stay in SYNC with idx=1 (restart on this byte). Otherwise go to HUNT.
- LOCKED, match: idx increments; seq_done pulses on idx 7. gcnt is not used.
- LOCKED, mismatch:
  - error pulses and err_count increments.
  - locked drops.
  - Next state and idx follow the SYNC mismatch rule (SYNC with idx=1 if data==AF, else HUNT), with gcnt=0.
- err_count saturates at 2^ERR_CNT_W-1 and never wraps. Only reset clears it.
- exp_data is table[idx] in SYNC and LOCKED, and 8'hAF in HUNT.
- The duplicate E2 (idx 2 and idx 5) carries no special alignment meaning. Only AF starts a sequence.

## Timing
- All outputs are registered. The response to a byte sampled at edge N is visible after edge N; latency is 1 clock.
- seq_done and error are high for exactly one cycle per event. They can never both be high in the same cycle.
- With LOCK_PERIODS=L and a clean stream starting at AF, locked rises on the cycle after the L-th 8'h8D, i.e. after 8·L valid bytes.
- Reset (asynchronous, any time, including mid-sequence or while locked):
  - state=HUNT, idx=0, gcnt=0
  - locked=0, seq_done=0, error=0, err_count=0, exp_data=8'hAF
- On reset deassertion the first valid edge is evaluated as HUNT.
- Gaps (valid=0) of any length inside a sequence are transparent. They cause no error and no state change.

## Test plan
- Reset, then a clean stream of 3 sequences with valid=1 continuously, LOCK_PERIODS=2:
  - seq_done pulses after bytes 8, 16 and 24.
  - locked rises after byte 16.
  - error never pulses; err_count=0.
- Leading junk 00, 12, E2 followed by a clean sequence:
  - No error during the junk.
  - HUNT exits on AF.
  - seq_done pulses after the 8th byte of the sequence.
- Locked stream with byte idx 4 corrupted to 8'hFE:
  - error pulses one cycle after the bad byte; err_count=1.
  - locked falls on that cycle; state=HUNT.
  - Relock requires 2 further full sequences.
- Mismatch byte equal to AF, e.g. AF, BC, AF, BC, E2, ...:
  - One error pulse.
  - Checker restarts at idx=1 and completes that sequence; seq_done fires after its 8D.
- Clean sequence with random valid=0 gaps of 1-5 cycles: identical seq_done and locked results to the gap-free run; no errors.
- ERR_CNT_W=2 with 5 forced mismatches: err_count reads 1, 2, 3, 3, 3.
- Asynchronous reset asserted mid-sequence while locked: all outputs clear without waiting for a clock edge.
